weight_update: RTL and testbench
================================

Name: weight_update

Overview:
- Backpropagation stage directly downstream of a single perceptron.
- Takes the perceptron's activation, current weights and bias, input vector and target.
- Computes the output-layer error term, then the updated weights and bias, serially in signed fixed point.
- Presents the results with a one-cycle write strobe so the perceptron can store them; also exports the delta for the layer upstream.

Parameters:
NUM, 2, number of inputs/weights per perceptron
WIDTH, 32, bits per fixed-point word (signed two's complement)
FRAC, 16, fractional bits (Q(WIDTH-FRAC).FRAC); 1.0 = 2^FRAC
LR, 32'h0000_8000, learning rate in the same Q format (default 0.5)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
i_start  input  1  request one update; sampled only in IDLE
i_k  input  NUM*WIDTH  perceptron inputs; slice j = [(j+1)*WIDTH-1 : j*WIDTH]
i_a  input  WIDTH  perceptron activation (sigmoid output)
i_t  input  WIDTH  target value
i_w  input  NUM*WIDTH  current weights, same packing as i_k
i_b  input  WIDTH  current bias
o_w  output  NUM*WIDTH  updated weights
o_b  output  WIDTH  updated bias
o_delta  output  WIDTH  delta = (t-a)*a*(1-a), unscaled by LR
o_wr  output  1  one-cycle strobe: o_w/o_b valid, consumer stores {o_b, o_w}
o_busy  output  1  high while an update is in progress

Behaviour:
- Reset (async, any state): state=IDLE; o_w=0, o_b=0, o_delta=0, o_wr=0, o_busy=0; index counter=0. Reset mid-update aborts it; no o_wr is issued.
- IDLE: on a clock edge with i_start=1, latch i_k, i_a, i_t, i_w, i_b into internal registers and go to ERR. Inputs may change freely afterwards. i_start is ignored in every other state.
- ERR: err = t - a, saturating. Next state is DERIV.
- DERIV: d = a*(ONE - a); delta = err*d; o_delta <= delta. Next state is SCALE.
- SCALE: g = LR*delta. Next state is UPD with k=0.
- UPD: w[k] <= w[k] + g*x[k], saturating. Advance k each cycle. When k=NUM-1, go to BIAS.
- BIAS: b <= b + g, saturating. Next state is WRITE.
- WRITE: o_wr=1 for this cycle only; o_w/o_b already hold the new values. Next state is IDLE.
- Latency: if edge E0 samples i_start, o_wr is high in the cycle after edge E(NUM+4) (for NUM=2, after E6). Back-to-back starts are accepted from the first IDLE cycle, giving a throughput of one update per NUM+6 cycles.
- o_busy is high from after E0 through the WRITE cycle inclusive; it is low in IDLE.
- o_w, o_b and o_delta hold their values between updates. o_w[k] is updated in place during UPD, so o_w is valid only when o_wr=1.
- Multiply rule: full 2*WIDTH signed product, arithmetic shift right by FRAC (truncation toward -inf), then saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Add/subtract rule: WIDTH+1-bit result, saturated to the same range.
- No division and no rounding beyond the truncation above.

Decomposition:
- Shared package, fxp_pkg: FRAC default, ONE, SAT_MAX and SAT_MIN constants, and the state enum (IDLE, ERR, DERIV, SCALE, UPD, BIAS, WRITE).
- One sub-module, fxp_mul_sat (WIDTH, FRAC): combinational signed multiply, shift and saturate.
  - Instantiate one shared copy, muxed by state, so that one multiply is performed per cycle.
- Saturating add is a package function.

Test Plan:
- Nominal, NUM=2 (Q16.16): a=0x8000, t=0x10000, k={0x10000, 0xFFFE0000}, w={0x4000, 0}, b=0, start pulse.
  - Required: o_delta=0x2000; o_wr after E6; o_w[0]=0x5000, o_w[1]=0xFFFFE000, o_b=0x1000; o_busy spans E0+ to the WRITE cycle.
- Zero error: t=a=0x8000, other inputs as above -> o_delta=0, outputs equal the latched w and b, o_wr still pulses once.
- Saturation: w[0]=0x7FFFF000, g*x[0]=+0x2000 -> o_w[0]=0x7FFFFFFF. Mirror with w[1]=0x80001000 and a negative step -> 0x80000000.
- Input stability: change i_k, i_w and i_t on the cycle after E0, and pulse i_start during UPD.
  - Required: results match the first-sampled values; no second o_wr until a new start is given in IDLE.
- Reset mid-op: assert rst during UPD -> all outputs 0 immediately, and no o_wr. After release, a start yields the nominal result.
- Back-to-back: assert i_start in the first IDLE cycle after WRITE -> second o_wr exactly NUM+6 cycles after the first.

Source files
------------

// File: rtl/fxp_pkg.sv
// Shared fixed-point constants, the update FSM state type and the saturating adder.
// Constants are Q16.16 defaults; sat_add takes the target width so wider words work too.
package fxp_pkg;

    localparam int          FXP_WIDTH = 32;
    localparam int          FXP_FRAC  = 16;
    localparam logic [31:0] ONE       = 32'h0001_0000;
    localparam logic [31:0] SAT_MAX   = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN   = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        DERIV,
        SCALE,
        UPD,
        BIAS,
        WRITE
    } state_t;

    // Operands arrive sign-extended to 64 bits, so the raw sum cannot overflow.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int width);
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        if (sum > hi) return hi;
        if (sum < lo) return lo;
        return sum;
    endfunction

endpackage

// File: rtl/fxp_mul_sat.sv
// Combinational signed fixed-point multiply: full product, arithmetic shift by FRAC,
// then clamp to the signed WIDTH-bit range.
module fxp_mul_sat #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] shr;
    logic [WIDTH:0]     top_bits;

    assign a_ext    = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_ext    = {{WIDTH{b[WIDTH-1]}}, b};
    assign prod     = a_ext * b_ext;
    assign shr      = $unsigned($signed(prod) >>> FRAC);
    // The result fits iff every bit above the WIDTH-bit sign position matches it.
    assign top_bits = shr[2*WIDTH-1:WIDTH-1];

    always_comb begin
        if ((&top_bits) || !(|top_bits)) begin
            y = shr[WIDTH-1:0];
        end else if (shr[2*WIDTH-1]) begin
            y = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            y = {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/weight_update.sv
// Serial backprop update for one perceptron: error, delta, scaled gradient, per-weight
// update and bias update, using one shared multiplier; o_wr strobes the finished result.
module weight_update
    import fxp_pkg::*;
#(
    parameter int               NUM   = 2,
    parameter int               WIDTH = FXP_WIDTH,
    parameter int               FRAC  = FXP_FRAC,
    parameter logic [WIDTH-1:0] LR    = WIDTH'(32'h0000_8000)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [NUM*WIDTH-1:0] i_k,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_t,
    input  logic [NUM*WIDTH-1:0] i_w,
    input  logic [WIDTH-1:0]     i_b,
    output logic [NUM*WIDTH-1:0] o_w,
    output logic [WIDTH-1:0]     o_b,
    output logic [WIDTH-1:0]     o_delta,
    output logic                 o_wr,
    output logic                 o_busy,
    output state_t               dbg_state
);

    localparam int               KW    = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1) << FRAC;

    state_t           state;
    state_t           next;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_r, t_r, b_r, err_r, d_r, g_r;
    logic [WIDTH-1:0] x_r [NUM];
    logic [WIDTH-1:0] w_r [NUM];
    logic [WIDTH-1:0] mul_a, mul_b, mul_y;
    logic [WIDTH-1:0] err_sum, one_minus_a, upd_sum, bias_sum;

    function automatic logic signed [63:0] sx(input logic [WIDTH-1:0] v);
        return {{(64-WIDTH){v[WIDTH-1]}}, v};
    endfunction

    function automatic logic [WIDTH-1:0] sat_w(input logic signed [63:0] a,
                                               input logic signed [63:0] b);
        logic signed [63:0] s;
        s = sat_add(a, b, WIDTH);
        return s[WIDTH-1:0];
    endfunction

    assign err_sum     = sat_w(sx(t_r), -sx(a_r));
    assign one_minus_a = sat_w(sx(ONE_Q), -sx(a_r));
    assign upd_sum     = sat_w(sx(w_r[k]), sx(mul_y));
    assign bias_sum    = sat_w(sx(b_r), sx(g_r));

    fxp_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (
        .a (mul_a),
        .b (mul_b),
        .y (mul_y)
    );

    // a*(1-a) is formed during ERR so that every state needs at most one product.
    always_comb begin
        next  = state;
        mul_a = '0;
        mul_b = '0;
        unique case (state)
            IDLE:  if (i_start) next = ERR;
            ERR:   begin mul_a = a_r;   mul_b = one_minus_a; next = DERIV; end
            DERIV: begin mul_a = err_r; mul_b = d_r;         next = SCALE; end
            SCALE: begin mul_a = LR;    mul_b = o_delta;     next = UPD;   end
            UPD: begin
                mul_a = g_r;
                mul_b = x_r[k];
                if (k == KW'(NUM - 1)) next = BIAS;
            end
            BIAS:    next = WRITE;
            WRITE:   next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k       <= '0;
            a_r     <= '0;
            t_r     <= '0;
            b_r     <= '0;
            err_r   <= '0;
            d_r     <= '0;
            g_r     <= '0;
            o_w     <= '0;
            o_b     <= '0;
            o_delta <= '0;
            for (int j = 0; j < NUM; j++) begin
                x_r[j] <= '0;
                w_r[j] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: if (i_start) begin
                    a_r <= i_a;
                    t_r <= i_t;
                    b_r <= i_b;
                    for (int j = 0; j < NUM; j++) begin
                        x_r[j] <= i_k[j*WIDTH +: WIDTH];
                        w_r[j] <= i_w[j*WIDTH +: WIDTH];
                    end
                end
                ERR: begin
                    err_r <= err_sum;
                    d_r   <= mul_y;
                end
                DERIV: o_delta <= mul_y;
                SCALE: begin
                    g_r <= mul_y;
                    k   <= '0;
                end
                UPD: begin
                    o_w[k*WIDTH +: WIDTH] <= upd_sum;
                    k <= k + 1'b1;
                end
                BIAS:    o_b <= bias_sum;
                default: ;
            endcase
        end
    end

    assign o_wr      = (state == WRITE);
    assign o_busy    = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_weight_update.sv
// Directed plus randomized bench for weight_update (NUM=2, Q16.16, LR=0.5); expected
// results come from an arithmetic reference model and are queued per update.
module tb_weight_update;

    localparam int          NUM = 2;
    localparam int          W   = 32;
    localparam logic [31:0] ONE = 32'h0001_0000;
    localparam logic [31:0] LR  = 32'h0000_8000;

    logic               clk;
    logic               rst;
    logic               i_start;
    logic [NUM*W-1:0]   i_k;
    logic [W-1:0]       i_a;
    logic [W-1:0]       i_t;
    logic [NUM*W-1:0]   i_w;
    logic [W-1:0]       i_b;
    logic [NUM*W-1:0]   o_w;
    logic [W-1:0]       o_b;
    logic [W-1:0]       o_delta;
    logic               o_wr;
    logic               o_busy;
    fxp_pkg::state_t    dbg_state;

    int           checks = 0;
    int           fails  = 0;
    logic [W-1:0] exp_q[$];

    weight_update #(.NUM(NUM), .WIDTH(W), .FRAC(16), .LR(LR)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_k       (i_k),
        .i_a       (i_a),
        .i_t       (i_t),
        .i_w       (i_w),
        .i_b       (i_b),
        .o_w       (o_w),
        .o_b       (o_b),
        .o_delta   (o_delta),
        .o_wr      (o_wr),
        .o_busy    (o_busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] sat(input longint v);
        if (v > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (v < -64'sd2147483648) return 32'h8000_0000;
        return v[31:0];
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return sat(p >>> 16);
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        return sat(longint'($signed(x)) + longint'($signed(y)));
    endfunction

    function automatic logic [31:0] fsub(input logic [31:0] x, input logic [31:0] y);
        return sat(longint'($signed(x)) - longint'($signed(y)));
    endfunction

    // Drives one update's operands and queues its expected delta, w0, w1, b.
    task automatic setup(input logic [31:0] a, input logic [31:0] t,
                         input logic [31:0] k0, input logic [31:0] k1,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] b);
        logic [31:0] delta, g;
        i_a = a;
        i_t = t;
        i_k = {k1, k0};
        i_w = {w1, w0};
        i_b = b;
        delta = fmul(fsub(t, a), fmul(a, fsub(ONE, a)));
        g     = fmul(LR, delta);
        exp_q.push_back(delta);
        exp_q.push_back(fadd(w0, fmul(g, k0)));
        exp_q.push_back(fadd(w1, fmul(g, k1)));
        exp_q.push_back(fadd(b, g));
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_results(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() < 4) begin
            check({tag, "_queue"}, 32'(exp_q.size()), 32'd4);
            return;
        end
        e = exp_q.pop_front(); check({tag, "_delta"}, o_delta, e);
        e = exp_q.pop_front(); check({tag, "_w0"}, o_w[31:0], e);
        e = exp_q.pop_front(); check({tag, "_w1"}, o_w[63:32], e);
        e = exp_q.pop_front(); check({tag, "_b"}, o_b, e);
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge in IDLE; returns at the negedge after the sampling edge E0.
    task automatic pulse_start();
        i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Counts cycles from the post-E0 negedge to the WRITE cycle, checking busy each cycle.
    task automatic wait_wr(input string tag, input bit disturb, output int n);
        n = 0;
        while (!o_wr && n < 40) begin
            check({tag, "_busy"}, 32'(o_busy), 32'd1);
            if (disturb && n == 0) begin
                i_k = {$urandom(), $urandom()};
                i_w = {$urandom(), $urandom()};
                i_t = $urandom();
            end
            if (disturb && n == 3) i_start = 1'b1;
            if (disturb && n == 4) i_start = 1'b0;
            @(negedge clk);
            n++;
        end
        check({tag, "_wr"}, 32'(o_wr), 32'd1);
        check({tag, "_busy_wr"}, 32'(o_busy), 32'd1);
    endtask

    task automatic run_one(input string tag, input bit disturb);
        int n;
        pulse_start();
        wait_wr(tag, disturb, n);
        check({tag, "_latency"}, 32'(n), 32'(NUM + 4));
        check_results(tag);
        @(negedge clk);
        check({tag, "_wr_drop"}, 32'(o_wr), 32'd0);
        check({tag, "_idle"}, 32'(o_busy), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int cnt;
        rst     = 1'b1;
        i_start = 1'b0;
        i_k     = '0;
        i_w     = '0;
        i_a     = '0;
        i_t     = '0;
        i_b     = '0;
        repeat (3) @(negedge clk);
        check("rst_w", o_w[31:0], 32'd0);
        check("rst_b", o_b, 32'd0);
        check("rst_delta", o_delta, 32'd0);
        check("rst_wr", 32'(o_wr), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(fxp_pkg::IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Nominal case, with hand-derived constants as well as the model.
        setup(32'h8000, 32'h10000, 32'h10000, 32'hFFFE_0000, 32'h4000, 32'h0, 32'h0);
        run_one("nom", 1'b0);
        check("nom_delta_const", o_delta, 32'h2000);
        check("nom_w0_const", o_w[31:0], 32'h5000);
        check("nom_w1_const", o_w[63:32], 32'hFFFF_E000);
        check("nom_b_const", o_b, 32'h1000);

        // Zero error: outputs equal the latched weights and bias.
        setup(32'h8000, 32'h8000, 32'h10000, 32'hFFFE_0000, 32'h4000, 32'h0, 32'h0);
        run_one("zero", 1'b0);
        check("zero_delta_const", o_delta, 32'h0);
        check("zero_w0_const", o_w[31:0], 32'h4000);

        // Saturation in both directions.
        setup(32'h8000, 32'h10000, 32'h20000, 32'hFFFE_0000, 32'h7FFF_F000, 32'h8000_1000, 32'h0);
        run_one("sat", 1'b0);
        check("sat_w0_const", o_w[31:0], 32'h7FFF_FFFF);
        check("sat_w1_const", o_w[63:32], 32'h8000_0000);

        // Inputs disturbed after E0 and a stray start during UPD.
        setup(32'h8000, 32'h10000, 32'h10000, 32'hFFFE_0000, 32'h4000, 32'h0, 32'h0);
        run_one("stable", 1'b1);
        for (int i = 0; i < 12; i++) begin
            check("stable_no_second_wr", 32'(o_wr), 32'd0);
            @(negedge clk);
        end

        // Reset during UPD aborts the update.
        setup(32'h8000, 32'h10000, 32'h10000, 32'hFFFE_0000, 32'h4000, 32'h0, 32'h0);
        void'(exp_q.pop_front()); void'(exp_q.pop_front());
        void'(exp_q.pop_front()); void'(exp_q.pop_front());
        pulse_start();
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_w0", o_w[31:0], 32'd0);
        check("mid_rst_w1", o_w[63:32], 32'd0);
        check("mid_rst_b", o_b, 32'd0);
        check("mid_rst_delta", o_delta, 32'd0);
        check("mid_rst_wr", 32'(o_wr), 32'd0);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_no_wr", 32'(o_wr), 32'd0);
        end
        setup(32'h8000, 32'h10000, 32'h10000, 32'hFFFE_0000, 32'h4000, 32'h0, 32'h0);
        run_one("after_rst", 1'b0);

        // Back-to-back: second start in the first IDLE cycle after WRITE.
        setup(32'h8000, 32'h10000, 32'h10000, 32'hFFFE_0000, 32'h4000, 32'h0, 32'h0);
        pulse_start();
        wait_wr("b2b_first", 1'b0, n);
        check_results("b2b_first");
        setup(32'h4000, 32'h0, 32'h30000, 32'h10000, 32'hFFFF_0000, 32'h2000, 32'h100);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) i_start = 1'b1;
            if (cnt == 2) i_start = 1'b0;
        end while (!o_wr && cnt < 40);
        check("b2b_spacing", 32'(cnt), 32'(NUM + 6));
        check_results("b2b_second");
        @(negedge clk);

        // Randomized updates against the model.
        for (int i = 0; i < 20; i++) begin
            logic [31:0] ra, rt, rk0, rk1, rw0, rw1, rb;
            ra  = $urandom_range(0, 32'h10000);
            rt  = $urandom_range(0, 32'h10000);
            rk0 = $urandom_range(0, 32'h000F_FFFF) - 32'h0008_0000;
            rk1 = $urandom_range(0, 32'h000F_FFFF) - 32'h0008_0000;
            rw0 = (i % 4 == 3) ? $urandom() : $urandom_range(0, 32'h000F_FFFF) - 32'h0008_0000;
            rw1 = (i % 5 == 4) ? $urandom() : $urandom_range(0, 32'h000F_FFFF) - 32'h0008_0000;
            rb  = (i % 3 == 2) ? $urandom() : $urandom_range(0, 32'h000F_FFFF) - 32'h0008_0000;
            setup(ra, rt, rk0, rk1, rw0, rw1, rb);
            run_one("rand", 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
